// File: rtl/dma_pkg.sv
// Shared definitions for the channel-2 DMA engine: IO register map,
// mode-byte field positions, transfer-type encodings and FSM states.
package dma_pkg;

  localparam logic [9:0] REG_ADDR     = 10'h004;
  localparam logic [9:0] REG_COUNT    = 10'h005;
  localparam logic [9:0] REG_STATUS   = 10'h008;
  localparam logic [9:0] REG_MASK1    = 10'h00A;
  localparam logic [9:0] REG_MODE     = 10'h00B;
  localparam logic [9:0] REG_CLR_FF   = 10'h00C;
  localparam logic [9:0] REG_MCLR     = 10'h00D;
  localparam logic [9:0] REG_MASK_ALL = 10'h00F;

  // Single-mask and mode writes carry a channel select in bits [1:0]
  localparam logic [1:0] CH_SEL = 2'd2;
  localparam int MASK_BIT = 2;

  // Mode byte fields
  localparam int MODE_TYPE_LSB = 2;
  localparam int MODE_AUTOINIT = 4;
  localparam int MODE_DEC      = 5;

  // Status byte fields
  localparam int STAT_TC_BIT  = 2;
  localparam int STAT_DRQ_BIT = 6;

  typedef enum logic [1:0] {
    XFER_VERIFY     = 2'b00,
    XFER_WRITE      = 2'b01,
    XFER_READ       = 2'b10,
    XFER_VERIFY_ALT = 2'b11
  } xfer_t;

  typedef enum logic [2:0] {IDLE, REQ, S1, S2, S3, S4} dma_state_t;

endpackage

// File: rtl/dma_regfile.sv
// Programming registers for DMA channel 2: CPU IO decode, byte flip-flop,
// base/current address and count, mask, mode, page, status and read mux.
module dma_regfile
  import dma_pkg::*;
#(
  parameter int               IO_AW     = 10,
  parameter logic [IO_AW-1:0] PAGE_PORT = 10'h081
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IO_AW-1:0] io_addr,
  input  logic [7:0]       io_wdata,
  output logic [7:0]       io_rdata,
  output logic             io_rd_en,
  input  logic             ior_n_in,
  input  logic             iow_n_in,
  input  logic             aen,
  input  logic             drq2,
  input  logic             upd_en,
  input  logic [15:0]      upd_addr,
  input  logic [15:0]      upd_count,
  input  logic             tc_set,
  input  logic             mask_set,
  output logic             mclr,
  output logic [15:0]      cur_addr,
  output logic [15:0]      cur_count,
  output logic [15:0]      base_addr,
  output logic [15:0]      base_count,
  output logic [3:0]       page,
  output logic [1:0]       xfer_type,
  output logic             autoinit,
  output logic             decrement,
  output logic             mask
);

  localparam logic [IO_AW-1:0] A_ADDR     = IO_AW'(REG_ADDR);
  localparam logic [IO_AW-1:0] A_COUNT    = IO_AW'(REG_COUNT);
  localparam logic [IO_AW-1:0] A_STATUS   = IO_AW'(REG_STATUS);
  localparam logic [IO_AW-1:0] A_MASK1    = IO_AW'(REG_MASK1);
  localparam logic [IO_AW-1:0] A_MODE     = IO_AW'(REG_MODE);
  localparam logic [IO_AW-1:0] A_CLR_FF   = IO_AW'(REG_CLR_FF);
  localparam logic [IO_AW-1:0] A_MCLR     = IO_AW'(REG_MCLR);
  localparam logic [IO_AW-1:0] A_MASK_ALL = IO_AW'(REG_MASK_ALL);

  logic        iow_q, ior_q;
  logic        wr_edge, wr_stb, rd_end, rd_hit;
  logic        ff_q, mask_q, tc_flag_q, autoinit_q, decrement_q;
  logic [1:0]  xfer_type_q;
  logic [3:0]  page_q;
  logic [15:0] base_addr_q, base_count_q, cur_addr_q, cur_count_q;
  logic [7:0]  status_byte;

  assign wr_edge = iow_q & ~iow_n_in;
  assign wr_stb  = wr_edge & ~aen;
  // Master clear is honoured even while the DMA owns the bus so the CPU
  // can always abort a transfer in flight.
  assign mclr    = wr_edge & (io_addr == A_MCLR);
  assign rd_end  = ~ior_q & ior_n_in & ~aen & rd_hit;

  // Previous strobe levels for falling/rising edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iow_q <= 1'b1;
      ior_q <= 1'b1;
    end else begin
      iow_q <= iow_n_in;
      ior_q <= ior_n_in;
    end
  end

  // Register storage: CPU writes, read side effects and per-byte updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q         <= 1'b0;
      mask_q       <= 1'b1;
      tc_flag_q    <= 1'b0;
      autoinit_q   <= 1'b0;
      decrement_q  <= 1'b0;
      xfer_type_q  <= 2'b00;
      page_q       <= 4'h0;
      base_addr_q  <= 16'h0;
      base_count_q <= 16'h0;
      cur_addr_q   <= 16'h0;
      cur_count_q  <= 16'h0;
    end else if (mclr) begin
      ff_q         <= 1'b0;
      mask_q       <= 1'b1;
      tc_flag_q    <= 1'b0;
      autoinit_q   <= 1'b0;
      decrement_q  <= 1'b0;
      xfer_type_q  <= 2'b00;
      page_q       <= 4'h0;
      base_addr_q  <= 16'h0;
      base_count_q <= 16'h0;
      cur_addr_q   <= 16'h0;
      cur_count_q  <= 16'h0;
    end else begin
      if (wr_stb) begin
        case (io_addr)
          A_ADDR: begin
            if (ff_q) begin
              base_addr_q[15:8] <= io_wdata;
              cur_addr_q[15:8]  <= io_wdata;
            end else begin
              base_addr_q[7:0] <= io_wdata;
              cur_addr_q[7:0]  <= io_wdata;
            end
            ff_q <= ~ff_q;
          end
          A_COUNT: begin
            if (ff_q) begin
              base_count_q[15:8] <= io_wdata;
              cur_count_q[15:8]  <= io_wdata;
            end else begin
              base_count_q[7:0] <= io_wdata;
              cur_count_q[7:0]  <= io_wdata;
            end
            ff_q <= ~ff_q;
          end
          A_MASK1: begin
            if (io_wdata[1:0] == CH_SEL) mask_q <= io_wdata[MASK_BIT];
          end
          A_MODE: begin
            if (io_wdata[1:0] == CH_SEL) begin
              xfer_type_q <= io_wdata[MODE_TYPE_LSB +: 2];
              autoinit_q  <= io_wdata[MODE_AUTOINIT];
              decrement_q <= io_wdata[MODE_DEC];
            end
          end
          A_CLR_FF:   ff_q   <= 1'b0;
          A_MASK_ALL: mask_q <= io_wdata[MASK_BIT];
          PAGE_PORT:  page_q <= io_wdata[3:0];
          default: ;
        endcase
      end
      if (rd_end) begin
        case (io_addr)
          A_ADDR, A_COUNT: ff_q      <= ~ff_q;
          A_STATUS:        tc_flag_q <= 1'b0;
          default: ;
        endcase
      end
      if (upd_en) begin
        cur_addr_q  <= upd_addr;
        cur_count_q <= upd_count;
        if (tc_set)   tc_flag_q <= 1'b1;
        if (mask_set) mask_q    <= 1'b1;
      end
    end
  end

  // Read decode and data mux for the readable registers
  always_comb begin
    status_byte               = 8'h00;
    status_byte[STAT_TC_BIT]  = tc_flag_q;
    status_byte[STAT_DRQ_BIT] = drq2;
    rd_hit   = 1'b0;
    io_rdata = 8'h00;
    case (io_addr)
      A_ADDR: begin
        rd_hit   = 1'b1;
        io_rdata = ff_q ? cur_addr_q[15:8] : cur_addr_q[7:0];
      end
      A_COUNT: begin
        rd_hit   = 1'b1;
        io_rdata = ff_q ? cur_count_q[15:8] : cur_count_q[7:0];
      end
      A_STATUS: begin
        rd_hit   = 1'b1;
        io_rdata = status_byte;
      end
      PAGE_PORT: begin
        rd_hit   = 1'b1;
        io_rdata = {4'h0, page_q};
      end
      default: ;
    endcase
  end

  assign io_rd_en   = rd_hit & ~ior_n_in & ~aen;
  assign cur_addr   = cur_addr_q;
  assign cur_count  = cur_count_q;
  assign base_addr  = base_addr_q;
  assign base_count = base_count_q;
  assign page       = page_q;
  assign xfer_type  = xfer_type_q;
  assign autoinit   = autoinit_q;
  assign decrement  = decrement_q;
  assign mask       = mask_q;

endmodule

// File: rtl/dma_ch2.sv
// Channel-2 DMA engine: bus arbitration with the CPU, single-byte
// transfer sequencing and address/count stepping.
module dma_ch2
  import dma_pkg::*;
#(
  parameter int               IO_AW     = 10,
  parameter logic [IO_AW-1:0] PAGE_PORT = 10'h081
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IO_AW-1:0] io_addr,
  input  logic [7:0]       io_wdata,
  output logic [7:0]       io_rdata,
  output logic             io_rd_en,
  input  logic             ior_n_in,
  input  logic             iow_n_in,
  input  logic             aen,
  input  logic             drq2,
  output logic             dack2_n,
  output logic             tc,
  output logic             hold_req,
  input  logic             hold_ack,
  output logic [19:0]      dma_addr,
  output logic             addr_oe,
  output logic             memr_n,
  output logic             memw_n,
  output logic             dma_ior_n,
  output logic             dma_iow_n
);

  dma_state_t  state_q, state_d;
  logic        mclr, upd_en, is_tc, autoinit, decrement, mask;
  logic [1:0]  xfer_type;
  logic [3:0]  page;
  logic [15:0] cur_addr, cur_count, base_addr, base_count;
  logic [15:0] upd_addr, upd_count;

  dma_regfile #(
    .IO_AW     (IO_AW),
    .PAGE_PORT (PAGE_PORT)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_rd_en   (io_rd_en),
    .ior_n_in   (ior_n_in),
    .iow_n_in   (iow_n_in),
    .aen        (aen),
    .drq2       (drq2),
    .upd_en     (upd_en),
    .upd_addr   (upd_addr),
    .upd_count  (upd_count),
    .tc_set     (is_tc),
    .mask_set   (is_tc & ~autoinit),
    .mclr       (mclr),
    .cur_addr   (cur_addr),
    .cur_count  (cur_count),
    .base_addr  (base_addr),
    .base_count (base_count),
    .page       (page),
    .xfer_type  (xfer_type),
    .autoinit   (autoinit),
    .decrement  (decrement),
    .mask       (mask)
  );

  assign is_tc = (cur_count == 16'h0000);

  // Post-transfer address/count; terminal count with autoinit reloads base
  always_comb begin
    upd_addr  = decrement ? (cur_addr - 16'd1) : (cur_addr + 16'd1);
    upd_count = cur_count - 16'd1;
    if (is_tc && autoinit) begin
      upd_addr  = base_addr;
      upd_count = base_count;
    end
  end

  // State register; master clear aborts back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state_q <= IDLE;
    else if (mclr) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state and bus-cycle outputs
  always_comb begin
    state_d   = state_q;
    hold_req  = 1'b0;
    addr_oe   = 1'b0;
    dack2_n   = 1'b1;
    memr_n    = 1'b1;
    memw_n    = 1'b1;
    dma_ior_n = 1'b1;
    dma_iow_n = 1'b1;
    tc        = 1'b0;
    upd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (drq2 && !mask) state_d = REQ;
      end
      REQ: begin
        hold_req = 1'b1;
        if (drq2 && hold_ack) state_d = S1;
        else if (!drq2)       state_d = IDLE;
      end
      S1: begin
        hold_req = 1'b1;
        addr_oe  = 1'b1;
        dack2_n  = 1'b0;
        state_d  = S2;
      end
      S2, S3: begin
        hold_req = 1'b1;
        addr_oe  = 1'b1;
        dack2_n  = 1'b0;
        tc       = is_tc;
        case (xfer_t'(xfer_type))
          XFER_WRITE: begin
            dma_ior_n = 1'b0;
            memw_n    = 1'b0;
          end
          XFER_READ: begin
            memr_n    = 1'b0;
            dma_iow_n = 1'b0;
          end
          default: ;
        endcase
        state_d = (state_q == S2) ? S3 : S4;
      end
      S4: begin
        upd_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_addr = addr_oe ? {page, cur_addr} : 20'h00000;

endmodule

// File: tb/tb_dma_ch2.sv
// Self-checking bench for dma_ch2: register table plus transfer sequences.
module tb_dma_ch2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  io_addr = 10'h000;
  logic [7:0]  io_wdata = 8'h00;
  logic [7:0]  io_rdata;
  logic        io_rd_en;
  logic        ior_n_in = 1'b1;
  logic        iow_n_in = 1'b1;
  logic        aen = 1'b0;
  logic        drq2 = 1'b0;
  logic        dack2_n, tc, hold_req;
  logic        hold_ack = 1'b1;
  logic [19:0] dma_addr;
  logic        addr_oe, memr_n, memw_n, dma_ior_n, dma_iow_n;

  int nvec = 0;
  int nmiss = 0;

  typedef struct {
    logic       is_rd;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic       exp_en;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  dma_ch2 dut (
    .clk       (clk),
    .rst       (rst),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_rd_en  (io_rd_en),
    .ior_n_in  (ior_n_in),
    .iow_n_in  (iow_n_in),
    .aen       (aen),
    .drq2      (drq2),
    .dack2_n   (dack2_n),
    .tc        (tc),
    .hold_req  (hold_req),
    .hold_ack  (hold_ack),
    .dma_addr  (dma_addr),
    .addr_oe   (addr_oe),
    .memr_n    (memr_n),
    .memw_n    (memw_n),
    .dma_ior_n (dma_ior_n),
    .dma_iow_n (dma_iow_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nvec++;
    if (actual !== expected) begin
      nmiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic io_write(input logic [9:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    io_addr = a; io_wdata = d; iow_n_in = 1'b0;
    @(posedge clk); #1;
    iow_n_in = 1'b1;
  endtask

  task automatic io_read(input logic [9:0] a, output logic [7:0] d, output logic en);
    @(posedge clk); #1;
    io_addr = a; ior_n_in = 1'b0;
    #1;
    d  = io_rdata;
    en = io_rd_en;
    @(posedge clk); #1;
    ior_n_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] d;
    logic       en;
    if (v.is_rd) begin
      io_read(v.addr, d, en);
      checkOutput($sformatf("reg_vec%0d_rd_en", idx), {31'b0, en}, {31'b0, v.exp_en});
      checkOutput($sformatf("reg_vec%0d_rdata", idx), {24'b0, d}, {24'b0, v.exp_data});
    end else begin
      io_write(v.addr, v.wdata);
    end
  endtask

  task automatic read_check(input logic [9:0] a, input logic [7:0] exp, input string name);
    logic [7:0] d;
    logic       en;
    io_read(a, d, en);
    checkOutput({name, "_en"}, {31'b0, en}, 32'd1);
    checkOutput(name, {24'b0, d}, {24'b0, exp});
  endtask

  task automatic wait_s1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (addr_oe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // kind: 0 verify, 1 write (device->mem), 2 read (mem->device)
  task automatic run_transfer(input logic [19:0] exp_addr, input int kind, input bit exp_tc, input string tag);
    bit ok;
    bit done;
    int w, r, t;
    wait_s1(ok);
    if (!ok) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_addr"}, {12'b0, dma_addr}, {12'b0, exp_addr});
    w = 0; r = 0; t = 0; done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (!dma_ior_n && !memw_n) w++;
      if (!memr_n && !dma_iow_n) r++;
      if (tc) t++;
      if (dack2_n) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, "_wr_strobes"}, w, (kind == 1) ? 32'd2 : 32'd0);
    checkOutput({tag, "_rd_strobes"}, r, (kind == 2) ? 32'd2 : 32'd0);
    checkOutput({tag, "_tc_cycles"}, t, exp_tc ? 32'd2 : 32'd0);
  endtask

  task automatic no_transfer(input int n, input string tag);
    bit seen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (hold_req || addr_oe) seen = 1'b1;
    end
    checkOutput(tag, {31'b0, seen}, 32'd0);
  endtask

  task automatic program_ch(input logic [3:0] pg, input logic [15:0] a, input logic [15:0] c, input logic [7:0] mode);
    io_write(10'h00C, 8'h00);
    io_write(10'h004, a[7:0]);
    io_write(10'h004, a[15:8]);
    io_write(10'h005, c[7:0]);
    io_write(10'h005, c[15:8]);
    io_write(10'h081, {4'h0, pg});
    io_write(10'h00B, mode);
  endtask

  initial begin
    bit ok;
    vecs[0]  = '{1'b1, 10'h081, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 10'h008, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 10'h081, 8'h5A, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 10'h081, 8'h00, 1'b1, 8'h0A};
    vecs[4]  = '{1'b0, 10'h004, 8'h34, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 10'h004, 8'h12, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 10'h00C, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 10'h004, 8'h00, 1'b1, 8'h34};
    vecs[8]  = '{1'b1, 10'h004, 8'h00, 1'b1, 8'h12};
    vecs[9]  = '{1'b0, 10'h005, 8'hCD, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 10'h005, 8'hAB, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 10'h005, 8'h00, 1'b1, 8'hCD};
    vecs[12] = '{1'b1, 10'h005, 8'h00, 1'b1, 8'hAB};
    vecs[13] = '{1'b1, 10'h00B, 8'h00, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 10'h00A, 8'h01, 1'b0, 8'h00};
    vecs[15] = '{1'b1, 10'h008, 8'h00, 1'b1, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", {23'b0, dack2_n, memr_n, memw_n, dma_ior_n, dma_iow_n, hold_req, addr_oe, tc, io_rd_en}, {23'b0, 9'b1_1111_0000});
    checkOutput("reset_addr", {12'b0, dma_addr}, 32'd0);
    rst = 1'b0;

    $display("[TB] register table");
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

    // Mask is set from reset and the 0x0A write with wrong channel was ignored
    drq2 = 1'b1;
    no_transfer(10, "masked_after_reset");

    $display("[TB] write mode, increment, count 2");
    program_ch(4'h2, 16'h1000, 16'h0002, 8'h46);
    io_write(10'h00B, 8'h49);
    io_write(10'h00A, 8'h02);
    run_transfer(20'h21000, 1, 1'b0, "t1_b0");
    run_transfer(20'h21001, 1, 1'b0, "t1_b1");
    run_transfer(20'h21002, 1, 1'b1, "t1_b2");
    no_transfer(15, "t1_no_fourth");
    read_check(10'h008, 8'h44, "t1_status_a");
    read_check(10'h008, 8'h40, "t1_status_b");

    $display("[TB] read mode, decrement, count 1");
    drq2 = 1'b0;
    program_ch(4'h2, 16'h0001, 16'h0001, 8'h6A);
    io_write(10'h00A, 8'h02);
    drq2 = 1'b1;
    run_transfer(20'h20001, 2, 1'b0, "t2_b0");
    run_transfer(20'h20000, 2, 1'b1, "t2_b1");
    no_transfer(15, "t2_no_third");

    $display("[TB] autoinit, count 0");
    drq2 = 1'b0;
    program_ch(4'h2, 16'h0500, 16'h0000, 8'h56);
    io_write(10'h00A, 8'h02);
    drq2 = 1'b1;
    run_transfer(20'h20500, 1, 1'b1, "t3_b0");
    run_transfer(20'h20500, 1, 1'b1, "t3_b1");
    run_transfer(20'h20500, 1, 1'b1, "t3_b2");
    drq2 = 1'b0;
    read_check(10'h008, 8'h04, "t3_status");
    io_write(10'h00F, 8'h04);

    $display("[TB] address wrap, page held");
    program_ch(4'h3, 16'hFFFF, 16'h0001, 8'h46);
    io_write(10'h00A, 8'h02);
    drq2 = 1'b1;
    run_transfer(20'h3FFFF, 1, 1'b0, "t4_b0");
    run_transfer(20'h30000, 1, 1'b1, "t4_b1");
    drq2 = 1'b0;
    read_check(10'h081, 8'h03, "t4_page");

    $display("[TB] master clear during S2");
    program_ch(4'h2, 16'h0100, 16'h0005, 8'h46);
    io_write(10'h00A, 8'h02);
    drq2 = 1'b1;
    wait_s1(ok);
    checkOutput("t5_reach_s1", {31'b0, ok}, 32'd1);
    checkOutput("t5_s1_addr", {12'b0, dma_addr}, 32'h20100);
    @(posedge clk); #1;
    checkOutput("t5_s2_strobes", {30'b0, memw_n, dma_ior_n}, 32'd0);
    aen = 1'b1; io_addr = 10'h00D; io_wdata = 8'h00; iow_n_in = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5_mclr_ctrl", {24'b0, dack2_n, memr_n, memw_n, dma_ior_n, dma_iow_n, hold_req, addr_oe, tc}, {24'b0, 8'b1111_1000});
    checkOutput("t5_mclr_addr", {12'b0, dma_addr}, 32'd0);
    iow_n_in = 1'b1; aen = 1'b0;
    no_transfer(12, "t5_masked_after_mclr");
    io_write(10'h00A, 8'h02);
    run_transfer(20'h00000, 0, 1'b1, "t5_verify");
    drq2 = 1'b0;
    no_transfer(10, "t5_idle_end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule

// File: doc/dma_ch2.md
Name: dma_ch2

Overview:
Single-channel 8237-style DMA engine dedicated to channel 2. It is the block directly upstream of the floppy/SD controller: it answers that controller's drq2 and drives dack2_n and tc. It arbitrates for the system bus with the CPU via hold_req/hold_ack, then generates 20-bit memory addresses and paired memory/IO strobes. It also exposes the PC-compatible programming registers at IO 0x04/0x05/0x08/0x0A–0x0D/0x0F and page register 0x81.

Parameters:
IO_AW, 10, IO address bits decoded (PC ISA decode)
PAGE_PORT, 10'h081, IO address of channel-2 page register

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
io_addr  in  IO_AW  CPU IO address
io_wdata  in  8  CPU write data
io_rdata  out  8  register read data
io_rd_en  out  1  high while io_rdata must drive the data bus
ior_n_in  in  1  CPU IO read strobe, active-low
iow_n_in  in  1  CPU IO write strobe, active-low
aen  in  1  high = DMA owns bus; CPU IO decode disabled
drq2  in  1  request from floppy controller
dack2_n  out  1  acknowledge, active-low
tc  out  1  terminal count pulse
hold_req  out  1  bus request to CPU
hold_ack  in  1  bus grant from CPU
dma_addr  out  20  memory address {page, addr16}
addr_oe  out  1  dma_addr valid and driven
memr_n  out  1  memory read strobe
memw_n  out  1  memory write strobe
dma_ior_n  out  1  IO read strobe toward device
dma_iow_n  out  1  IO write strobe toward device

Behaviour:
- Reset and master clear (write 0x0D) give identical state:
  - all active-low outputs 1; hold_req, addr_oe, tc, io_rd_en 0; dma_addr 0
  - base/current addr and count 0, page 0, mode 0x00
  - mask set, byte flip-flop cleared, status 0, FSM IDLE
- Register writes: a CPU write is an iow_n_in falling edge (edge-detected on clk) with aen=0. Registers:
  - 0x04 base+current addr, 0x05 base+current count: low byte then high byte per flip-flop; each access toggles the flip-flop.
  - 0x0A: applies only if wdata[1:0]==2; bit2 sets/clears mask.
  - 0x0B mode: applies only if wdata[1:0]==2. Bits [3:2]: 01 write (device->mem), 10 read (mem->device), 00/11 verify (no strobes). Bit 4 autoinit. Bit 5 decrement. Bits [7:6] ignored; always single-transfer.
  - 0x0C clears flip-flop. 0x0F: bit2 is mask. PAGE_PORT: page[3:0] = wdata[3:0].
- Register reads: io_rd_en=1 combinationally while ior_n_in=0, aen=0, and the address hits a readable register.
  - 0x04/0x05 return the current value's byte selected by the flip-flop; the flip-flop toggles on the ior rising edge.
  - 0x08 returns status: bit2 = TC reached, bit6 = drq2 raw. Status bit2 clears on the ior rising edge.
  - PAGE_PORT returns {4'h0, page}.
- FSM, one state per clk:
  - IDLE: drq2=1 and mask=0 -> REQ; hold_req=1 from REQ onward.
  - REQ: wait for hold_ack=1 -> S1. If drq2 drops before the grant -> IDLE, hold_req dropped.
  - S1: addr_oe=1, dma_addr={page, cur_addr}, dack2_n=0.
  - S2, S3: strobes low per mode. Write mode: dma_ior_n=0, memw_n=0. Read mode: memr_n=0, dma_iow_n=0. tc=1 in S2–S3 when cur_count==0.
  - S4: strobes high, dack2_n=1, addr_oe=0, hold_req=0.
    - cur_addr ±1 wraps mod 2^16; page is never carried into.
    - cur_count-1 wraps; the 0 -> 0xFFFF transition is terminal count: status bit2 set.
    - On terminal count, autoinit=1 reloads current from base; otherwise mask is set.
    - Next state IDLE.
- Single-transfer mode: every byte releases the bus; IDLE holds hold_req low for at least 1 cycle before the next REQ.
- Transfer length = programmed count+1 bytes. Minimum per-byte latency from drq2 to the S1 address: 3 cycles with hold_ack already high.
- CPU register writes while the FSM is outside IDLE/REQ are ignored, because aen=1 then. A master clear in any state forces the reset state on the next clk.
- drq2 is assumed synchronous to clk; no synchronizer.

Decomposition:
- Shared package dma_pkg: register IO addresses, mode field positions, transfer-type encodings, FSM state enum {IDLE, REQ, S1, S2, S3, S4}.
- One natural sub-module, dma_regfile: IO decode, flip-flop, base/current/mask/mode/page/status storage, and the read mux. The top holds the FSM and address/count update.

Test Plan:
- Program page 0x02, addr 0x1000, count 0x0002, mode 0x46, unmask; hold drq2=1, hold_ack=1.
  - Required: 3 transfers at 0x21000, 0x21001, 0x21002 with dma_ior_n/memw_n low for 2 cycles each.
  - tc high only on the third; status read = 0x44 then 0x40; mask set; no 4th transfer.
- Mode 0x6A (read, decrement), addr 0x0001, count 1.
  - Required: addresses 0x?0001 then 0x?0000; memr_n/dma_iow_n asserted; tc on the second.
- Mode 0x56 (autoinit), count 0.
  - Required: tc on every transfer; current addr reloads to base after each; mask stays clear.
- Addr 0xFFFF, page 0x3, count 1.
  - Required: addresses 0x3FFFF then 0x30000; page unchanged.
- Write 0x0D during S2.
  - Required: next clk all strobes/dack2_n high, hold_req 0, mask set; drq2 ignored until unmasked.
- Flip-flop: write 0x04 bytes 0x34 then 0x12, write 0x0C, read 0x04 twice.
  - Required: returns 0x34 then 0x12; mode write with wdata[1:0]=1 leaves mode unchanged.
